// File: rtl/hcsr04_scheduler.sv
`timescale 1ns/1ps
// Round-robin HC-SR04 measurement sequencer: triggers one enabled sensor at a time,
// times its synchronised echo and publishes one tagged result per measurement.
module hcsr04_scheduler #(
  parameter int N              = 4,
  parameter int SEL_W          = (N > 1) ? $clog2(N) : 1,
  parameter int CNT_W          = 16,
  parameter int TRIG_CYCLES    = 6,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int HOLDOFF_CYCLES = 20
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_enable,
  input  logic [N-1:0]     i_sensor_mask,
  input  logic [N-1:0]     i_echo,
  output logic [N-1:0]     o_trig,
  output logic             o_busy,
  output logic [SEL_W-1:0] o_sel,
  output logic             o_result_valid,
  output logic [SEL_W-1:0] o_result_id,
  output logic [CNT_W-1:0] o_result_count,
  output logic             o_result_timeout
);

  localparam int TMR_MAX = (TRIG_CYCLES > HOLDOFF_CYCLES) ? TRIG_CYCLES : HOLDOFF_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [TMR_W-1:0] TRIG_LAST    = TMR_W'(TRIG_CYCLES - 1);
  localparam logic [TMR_W-1:0] HOLD_LAST    = TMR_W'(HOLDOFF_CYCLES);
  localparam logic [CNT_W-1:0] TO_COUNT     = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] TO_WAIT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [SEL_W-1:0] SEL_LAST     = SEL_W'(N - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TRIG,
    ST_WAIT_RISE,
    ST_MEASURE,
    ST_HOLDOFF
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [N-1:0]     r_echo_meta;
  logic [N-1:0]     r_echo_s;
  logic [SEL_W-1:0] r_sel;
  logic [SEL_W-1:0] r_ptr;
  logic [CNT_W-1:0] r_cnt;
  logic [TMR_W-1:0] r_tmr;
  logic             r_result_valid;
  logic [SEL_W-1:0] r_result_id;
  logic [CNT_W-1:0] r_result_count;
  logic             r_result_timeout;

  logic             w_echo_sel;
  logic             w_start;
  logic [SEL_W-1:0] w_pick;
  logic             w_pick_found;
  logic             w_finish;
  logic             w_fin_timeout;
  logic [CNT_W-1:0] w_fin_count;
  logic [N-1:0]     w_trig;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_echo_meta <= '0;
      r_echo_s    <= '0;
    end else begin
      r_echo_meta <= i_echo;
      r_echo_s    <= r_echo_meta;
    end
  end

  assign w_echo_sel = r_echo_s[r_sel];
  assign w_start    = i_enable && (|i_sensor_mask);

  // First masked-in sensor at or after the round-robin pointer, wrapping at N.
  always_comb begin
    w_pick       = r_ptr;
    w_pick_found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!w_pick_found && i_sensor_mask[(int'(r_ptr) + i) % N]) begin
        w_pick       = SEL_W'((int'(r_ptr) + i) % N);
        w_pick_found = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_finish      = 1'b0;
    w_fin_timeout = 1'b0;
    w_fin_count   = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_start) w_state_nxt = ST_TRIG;
      end
      ST_TRIG: begin
        if (r_tmr == TRIG_LAST) w_state_nxt = ST_WAIT_RISE;
      end
      ST_WAIT_RISE: begin
        if (w_echo_sel) begin
          w_state_nxt = ST_MEASURE;
        end else if (r_cnt == TO_WAIT_LAST) begin
          w_finish      = 1'b1;
          w_fin_timeout = 1'b1;
          w_state_nxt   = ST_HOLDOFF;
        end
      end
      ST_MEASURE: begin
        if (!w_echo_sel) begin
          w_finish    = 1'b1;
          w_fin_count = r_cnt;
          w_state_nxt = ST_HOLDOFF;
        end else if (r_cnt == TO_COUNT) begin
          w_finish      = 1'b1;
          w_fin_timeout = 1'b1;
          w_fin_count   = r_cnt;
          w_state_nxt   = ST_HOLDOFF;
        end
      end
      ST_HOLDOFF: begin
        if (r_tmr == HOLD_LAST) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // The result_valid cycle is the first HOLDOFF cycle, so HOLDOFF spans HOLDOFF_CYCLES+1 cycles.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sel            <= '0;
      r_ptr            <= '0;
      r_cnt            <= '0;
      r_tmr            <= '0;
      r_result_valid   <= 1'b0;
      r_result_id      <= '0;
      r_result_count   <= '0;
      r_result_timeout <= 1'b0;
    end else begin
      r_result_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_sel <= w_pick;
            r_cnt <= '0;
            r_tmr <= '0;
          end
        end
        ST_TRIG: begin
          r_cnt <= '0;
          r_tmr <= (r_tmr == TRIG_LAST) ? '0 : r_tmr + 1'b1;
        end
        ST_WAIT_RISE: begin
          r_cnt <= w_echo_sel ? CNT_W'(1) : r_cnt + 1'b1;
        end
        ST_MEASURE: begin
          if (!w_finish) r_cnt <= r_cnt + 1'b1;
        end
        ST_HOLDOFF: begin
          r_tmr <= r_tmr + 1'b1;
        end
        default: ;
      endcase
      if (w_finish) begin
        r_result_valid   <= 1'b1;
        r_result_id      <= r_sel;
        r_result_count   <= w_fin_count;
        r_result_timeout <= w_fin_timeout;
        r_tmr            <= '0;
        r_ptr            <= (r_sel == SEL_LAST) ? '0 : r_sel + 1'b1;
      end
    end
  end

  always_comb begin
    w_trig = '0;
    if (r_state == ST_TRIG) w_trig[r_sel] = 1'b1;
  end

  assign o_trig           = w_trig;
  assign o_busy           = (r_state != ST_IDLE);
  assign o_sel            = r_sel;
  assign o_result_valid   = r_result_valid;
  assign o_result_id      = r_result_id;
  assign o_result_count   = r_result_count;
  assign o_result_timeout = r_result_timeout;

endmodule
